// File: rtl/vaa8_pkg.sv
// Shared VAA8-S1 types: sequencer states, opcode classes
// and the opcode-to-class lookup used by fetch and decode.
package vaa8_pkg;

  typedef enum logic [2:0] {
    FETCH,
    IMM,
    ADDR_LO,
    ADDR_HI,
    READ,
    WRITE,
    EXEC,
    HALT
  } seq_state_t;

  typedef enum logic [2:0] {
    CLS_IMPLIED,
    CLS_IMMEDIATE,
    CLS_ABS_READ,
    CLS_ABS_WRITE,
    CLS_JUMP,
    CLS_STOP,
    CLS_UNKNOWN
  } op_class_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_TAX = 8'hAA;
  localparam logic [7:0] OP_INX = 8'hE8;
  localparam logic [7:0] OP_LDI = 8'hA9;
  localparam logic [7:0] OP_ADI = 8'h69;
  localparam logic [7:0] OP_LDA = 8'hAD;
  localparam logic [7:0] OP_STA = 8'h8D;
  localparam logic [7:0] OP_JMP = 8'h4C;
  localparam logic [7:0] OP_STP = 8'hDB;

  function automatic op_class_t op_class(
    input logic [7:0] opcode
  );
    case (opcode)
      OP_NOP, OP_TAX, OP_INX: return CLS_IMPLIED;
      OP_LDI, OP_ADI:         return CLS_IMMEDIATE;
      OP_LDA:                 return CLS_ABS_READ;
      OP_STA:                 return CLS_ABS_WRITE;
      OP_JMP:                 return CLS_JUMP;
      OP_STP:                 return CLS_STOP;
      default:                return CLS_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier, shared by the fetch
// sequencer and the instruction decoder.
module opcode_classifier
  import vaa8_pkg::*;
(
  input  logic [7:0] opcode,
  output op_class_t  cls
);

  assign cls = op_class(opcode);

endmodule

// File: rtl/fetch_sequencer.sv
// VAA8-S1 multi-cycle fetch/operand/execute controller:
// gathers opcode and operand bytes, forms eff_addr, strobes.
module fetch_sequencer
  import vaa8_pkg::*;
#(
  parameter logic [7:0] RESET_OPCODE   = 8'h00,
  parameter bit         ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  data_bus_in,
  input  logic [15:0] pc_value,
  output logic [7:0]  ir,
  output logic [7:0]  operand,
  output logic [15:0] eff_addr,
  output logic        addr_sel_eff,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        mem_we,
  output logic        exec_en,
  output logic        illegal_op,
  output logic        halted
);

  seq_state_t state;
  op_class_t  bus_cls;
  op_class_t  ir_cls;
  logic       pc_unused;

  // PC is owned by the CPU; it is carried only for bus symmetry
  assign pc_unused = ^pc_value;

  opcode_classifier u_bus_cls (
    .opcode (data_bus_in),
    .cls    (bus_cls)
  );

  opcode_classifier u_ir_cls (
    .opcode (ir),
    .cls    (ir_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      ir       <= RESET_OPCODE;
      operand  <= '0;
      eff_addr <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (run) begin
            ir <= data_bus_in;
            case (bus_cls)
              CLS_IMPLIED:   state <= EXEC;
              CLS_IMMEDIATE: state <= IMM;
              CLS_ABS_READ,
              CLS_ABS_WRITE,
              CLS_JUMP:      state <= ADDR_LO;
              CLS_STOP:      state <= HALT;
              default:
                state <= ILLEGAL_AS_NOP ? EXEC : HALT;
            endcase
          end
        end
        IMM: begin
          operand <= data_bus_in;
          state   <= EXEC;
        end
        ADDR_LO: begin
          eff_addr[7:0] <= data_bus_in;
          state         <= ADDR_HI;
        end
        ADDR_HI: begin
          eff_addr[15:8] <= data_bus_in;
          case (ir_cls)
            CLS_ABS_READ:  state <= READ;
            CLS_ABS_WRITE: state <= WRITE;
            CLS_JUMP:      state <= EXEC;
            default:       state <= FETCH;
          endcase
        end
        READ: begin
          operand <= data_bus_in;
          state   <= EXEC;
        end
        WRITE:   state <= FETCH;
        EXEC:    state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    addr_sel_eff = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    mem_we       = 1'b0;
    exec_en      = 1'b0;
    illegal_op   = 1'b0;
    halted       = 1'b0;
    case (state)
      FETCH: pc_inc = run;
      IMM, ADDR_LO, ADDR_HI: pc_inc = 1'b1;
      READ: addr_sel_eff = 1'b1;
      WRITE: begin
        addr_sel_eff = 1'b1;
        mem_we       = 1'b1;
      end
      EXEC: begin
        exec_en    = 1'b1;
        pc_load    = (ir_cls == CLS_JUMP);
        illegal_op = (ir_cls == CLS_UNKNOWN);
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: CPU/memory stub plus an
// instruction-level reference model checked every cycle.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  data_bus_in;
  logic [15:0] pc_value;
  logic [7:0]  ir;
  logic [7:0]  operand;
  logic [15:0] eff_addr;
  logic        addr_sel_eff;
  logic        pc_inc;
  logic        pc_load;
  logic        mem_we;
  logic        exec_en;
  logic        illegal_op;
  logic        halted;

  logic [7:0]  mem [65536];
  logic [15:0] pc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int phase = 0;

  typedef struct {
    logic [6:0]  str;
    logic [7:0]  ir;
    logic [7:0]  opnd;
    logic [15:0] ea;
  } cyc_t;

  cyc_t        q[$];
  logic [7:0]  m_ir;
  logic [7:0]  m_op;
  logic [15:0] m_ea;
  logic [15:0] mpc;
  bit          m_halt;

  fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .data_bus_in  (data_bus_in),
    .pc_value     (pc_value),
    .ir           (ir),
    .operand      (operand),
    .eff_addr     (eff_addr),
    .addr_sel_eff (addr_sel_eff),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .mem_we       (mem_we),
    .exec_en      (exec_en),
    .illegal_op   (illegal_op),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  assign pc_value = pc;

  always_comb begin
    data_bus_in = addr_sel_eff ? mem[eff_addr] : mem[pc];
  end

  always @(posedge clk) begin
    if (reset)        pc <= 16'h0000;
    else if (pc_load) pc <= eff_addr;
    else if (pc_inc)  pc <= pc + 16'd1;
  end

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h phase=%0d cyc=%0d",
               name, act, req, phase, cyc);
    end
  endfunction

  function automatic int cls(logic [7:0] o);
    case (o)
      8'h00, 8'hAA, 8'hE8: return 0;
      8'hA9, 8'h69:        return 1;
      8'hAD:               return 2;
      8'h8D:               return 3;
      8'h4C:               return 4;
      8'hDB:               return 5;
      default:             return 6;
    endcase
  endfunction

  // str = {pc_inc, pc_load, mem_we, exec_en, illegal_op, addr_sel_eff, halted}
  function automatic void push(logic [6:0] s);
    cyc_t c;
    c.str  = s;
    c.ir   = m_ir;
    c.opnd = m_op;
    c.ea   = m_ea;
    q.push_back(c);
  endfunction

  function automatic void build();
    logic [7:0]  op, b1, b2;
    logic [15:0] a1, a2;
    a1 = mpc + 16'd1;
    a2 = mpc + 16'd2;
    op = mem[mpc];
    b1 = mem[a1];
    b2 = mem[a2];
    push(7'b1000000);
    m_ir = op;
    case (cls(op))
      0: begin
        push(7'b0001000);
        mpc = mpc + 16'd1;
      end
      1: begin
        push(7'b1000000);
        m_op = b1;
        push(7'b0001000);
        mpc = mpc + 16'd2;
      end
      2, 3, 4: begin
        push(7'b1000000);
        m_ea[7:0] = b1;
        push(7'b1000000);
        m_ea[15:8] = b2;
        mpc = mpc + 16'd3;
        if (cls(op) == 2) begin
          push(7'b0000010);
          m_op = mem[m_ea];
          push(7'b0001000);
        end else if (cls(op) == 3) begin
          push(7'b0010010);
        end else begin
          push(7'b0101000);
          mpc = m_ea;
        end
      end
      5: m_halt = 1'b1;
      default: begin
        push(7'b0001100);
        mpc = mpc + 16'd1;
      end
    endcase
  endfunction

  task automatic check_cycle(bit rst, bit rn);
    cyc_t e;
    if (rst) begin
      q.delete();
      m_ir   = 8'h00;
      m_op   = 8'h00;
      m_ea   = 16'h0000;
      mpc    = 16'h0000;
      m_halt = 1'b0;
      cyc    = 0;
      return;
    end
    cyc++;
    if (q.size() == 0) begin
      if (m_halt)   push(7'b0000001);
      else if (!rn) push(7'b0000000);
      else          build();
    end
    e = q.pop_front();
    chk("strobes",
        {25'd0, pc_inc, pc_load, mem_we, exec_en,
         illegal_op, addr_sel_eff, halted},
        {25'd0, e.str});
    chk("ir", {24'd0, ir}, {24'd0, e.ir});
    chk("operand", {24'd0, operand}, {24'd0, e.opnd});
    chk("eff_addr", {16'd0, eff_addr}, {16'd0, e.ea});
    if (phase == 1) begin
      case (cyc)
        1: begin
          chk("rst_ir", {24'd0, ir}, 32'h00);
          chk("rst_halted", {31'd0, halted}, 32'd0);
          chk("first_inc", {31'd0, pc_inc}, 32'd1);
        end
        3:  chk("lda_imm", {23'd0, exec_en, operand}, 32'h142);
        7:  chk("sta_we", {14'd0, mem_we, addr_sel_eff, eff_addr},
                32'h38000);
        11: chk("jmp_load", {15'd0, pc_load, eff_addr}, 32'h11234);
        16: chk("lda_abs", {23'd0, exec_en, operand}, 32'h15A);
        18: chk("illegal", {31'd0, illegal_op}, 32'd1);
        30: chk("halt", {31'd0, halted}, 32'd1);
        default: ;
      endcase
    end else if (phase == 2) begin
      if (cyc == 10) chk("idle_pc", {16'd0, pc}, 32'h0);
      if (cyc == 11) chk("resume_inc", {31'd0, pc_inc}, 32'd1);
    end else if (phase == 3) begin
      chk("abort_we", {31'd0, mem_we}, 32'd0);
      chk("abort_ir", {24'd0, ir}, 32'h00);
    end
  endtask

  task automatic cycle(bit rst, bit rn);
    @(negedge clk);
    reset = rst;
    run   = rn;
    #1;
    check_cycle(rst, rn);
  endtask

  initial begin
    logic [7:0] tbl [10];
    tbl = '{8'h00, 8'hAA, 8'hE8, 8'hA9, 8'h69,
            8'hAD, 8'h8D, 8'h4C, 8'hFF, 8'h12};
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h42;
    mem[16'h0002] = 8'h8D; mem[16'h0003] = 8'h00;
    mem[16'h0004] = 8'h80;
    mem[16'h0005] = 8'h4C; mem[16'h0006] = 8'h34;
    mem[16'h0007] = 8'h12;
    mem[16'h1234] = 8'hAD; mem[16'h1235] = 8'h01;
    mem[16'h1236] = 8'h80;
    mem[16'h1237] = 8'hFF; mem[16'h1238] = 8'hDB;
    mem[16'h8001] = 8'h5A;

    phase = 1;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (30) cycle(1'b0, 1'b1);

    phase = 2;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b1);

    phase = 0;
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    phase = 3;
    repeat (3) cycle(1'b0, 1'b0);

    phase = 0;
    for (int i = 0; i < 65536; i++) begin
      if ($urandom_range(0, 9) < 8)
        mem[i] = tbl[$urandom_range(0, 9)];
      else
        mem[i] = 8'($urandom);
    end
    cycle(1'b1, 1'b0);
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 59) == 0,
            $urandom_range(0, 9) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle fetch/operand/execute controller for the VAA8-S1 CPU.
- Sits directly upstream of instruction_decoder and replaces the free-running instruction register.
- Fetches the opcode and 0–2 operand bytes from the system data bus, forms the effective address, and drives the address-source select.
- Issues exactly one execute strobe per instruction, and one write strobe for stores, so decoder controls and memory writes occur once.

Parameters:
- RESET_OPCODE, 8'h00, IR value after reset (NOP).
- ILLEGAL_AS_NOP, 1, 1: unknown opcodes execute as 1-byte NOP and pulse illegal_op; 0: unknown opcodes enter HALT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  1 = fetching allowed; sampled only in FETCH
- data_bus_in  in  8  system data bus (ROM/RAM/PIO mux), combinational read
- pc_value  in  16  current PC from CPU
- ir  out  8  instruction register, feeds instruction_decoder.opcode
- operand  out  8  immediate or memory-read byte
- eff_addr  out  16  absolute operand address
- addr_sel_eff  out  1  0: address bus = PC; 1: address bus = eff_addr
- pc_inc  out  1  one-cycle PC increment
- pc_load  out  1  one-cycle PC load of eff_addr (JMP)
- mem_we  out  1  one-cycle memory/peripheral write strobe (replaces opcode-compare write_enable)
- exec_en  out  1  one-cycle enable that gates all instruction_decoder register-load outputs
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- halted  out  1  level; high in HALT

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=FETCH, ir=RESET_OPCODE, operand=0, eff_addr=0.
  - All strobes 0, halted=0.
  - Reset mid-instruction aborts it: no mem_we or exec_en is issued afterwards.
- Opcode classes (package):
  - IMPLIED: NOP 00, TAX AA, INX E8.
  - IMMEDIATE: LDA# A9, ADC# 69.
  - ABS_READ: LDA AD.
  - ABS_WRITE: STA 8D.
  - JUMP: JMP 4C.
  - STOP: STP DB.
- All registered outputs update on the rising clk edge. Strobes are Moore outputs of the current state.
- FETCH, run=0: idle, no strobes, ir held.
- FETCH, run=1:
  - addr_sel_eff=0, pc_inc=1, ir<=data_bus_in.
  - Next state is chosen from the class of data_bus_in:
    - IMPLIED → EXEC
    - IMMEDIATE → IMM
    - ABS_* or JUMP → ADDR_LO
    - STOP → HALT
    - unknown → EXEC with illegal_op=1 (or HALT if ILLEGAL_AS_NOP=0)
- IMM: addr_sel_eff=0, operand<=data_bus_in, pc_inc=1 → EXEC.
- ADDR_LO: eff_addr[7:0]<=data_bus_in, pc_inc=1 → ADDR_HI.
- ADDR_HI: eff_addr[15:8]<=data_bus_in, pc_inc=1, then by class:
  - ABS_READ → READ
  - ABS_WRITE → WRITE
  - JUMP → EXEC
- READ: addr_sel_eff=1, operand<=data_bus_in → EXEC.
- WRITE: addr_sel_eff=1, mem_we=1 for exactly one cycle → FETCH. exec_en stays 0; the decoder drives reg_a_output_en from ir during WRITE.
- EXEC: exec_en=1 for one cycle; JUMP additionally pc_load=1 → FETCH.
- HALT: halted=1, no strobes, no exit except reset. run is ignored.
- Cycle counts (FETCH to next FETCH):
  - IMPLIED 2
  - IMMEDIATE 3
  - LDA abs 5
  - STA abs 4
  - JMP 4
- Invariants:
  - pc_inc and pc_load are never high together.
  - mem_we is never high while addr_sel_eff=0.
- eff_addr wrap: the PC increments past FFFF to 0000, which is the CPU's responsibility; the sequencer does no arithmetic on addresses.
- run is sampled only in FETCH. Deasserting run mid-instruction completes the current instruction.
- Encoding: one-hot or binary is implementer's choice. An unreachable state recovers to FETCH with no strobes.

Decomposition:
- Package vaa8_pkg:
  - seq_state_t enum (FETCH, IMM, ADDR_LO, ADDR_HI, READ, WRITE, EXEC, HALT)
  - op_class_t enum
  - opcode localparams
  - function op_class(opcode) returning op_class_t
- Optional sub-module: opcode_classifier, combinational, wrapping op_class; shared with instruction_decoder.

Test Plan:
- Reset: hold reset 2 cycles with data_bus_in=A9 → ir=00, all strobes 0, halted=0; first FETCH begins on the cycle after reset deasserts.
- Immediate load: ROM A9 42 → pc_inc on cycles 1–2, operand=42, exec_en on cycle 3 only, next FETCH on cycle 4.
- Store: ROM 8D 00 80 → eff_addr=8000, addr_sel_eff=1 and mem_we=1 for exactly one cycle (cycle 4), exec_en never high, 3 pc_inc pulses total.
- Jump and load: JMP 4C 34 12 → pc_load=1 with eff_addr=1234 in cycle 4. LDA AD 01 80 with RAM[8001]=5A → operand=5A, exec_en in cycle 5.
- Illegal/halt: unknown opcode FF → illegal_op one-cycle pulse and 2-cycle NOP. STP DB → halted=1 persistently with run=1; cleared only by reset.
- Reset mid-STA, asserted during ADDR_HI → no mem_we issued, state=FETCH. run=0 in FETCH → no pc_inc for 10 cycles; on run=1, fetch resumes.
